pipe_stage_buf: RTL and testbench

Parametrised elastic pipeline buffer between two pipeline stages (fetch→decode, decode→execute, execute→memory, memory→writeback). Holds up to DEPTH payload words of WIDTH bits in a circular queue with valid/ready handshakes, synchronous flush for branch/jump redirect, and selectable ready-path mode. Replaces the fixed single-entry stage registers and keeps each stage's packed struct (without its valid bit) as an opaque payload.

---
 rtl/pipe_stage_buf.sv | 95 +++++++++
 tb/tb_pipe_stage_buf.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic circular-queue buffer between two pipeline stages: valid/ready on
// both sides, synchronous flush for redirects, optional ready pass-through.
module pipe_stage_buf #(
  parameter int unsigned WIDTH      = 96,
  parameter int unsigned DEPTH      = 2,
  parameter bit          READY_PASS = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-two depths never index past DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full      = (count_q == DEPTH_C);
  assign out_valid = (count_q != '0) & ~flush;
  assign in_ready  = (~full | (READY_PASS & out_ready)) & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[head_q];
  assign count     = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Flush leaves payload words in place; only reset scrubs them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[tail_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: four configurations side by side, each compared
// every cycle against an ordered-list model of the buffer contents.
module tb_pipe_stage_buf;

  localparam int NI = 4;

  logic        clk;
  logic        reset;
  logic        fl   [NI];
  logic        iv   [NI];
  logic        ordy [NI];
  logic [15:0] din  [NI];
  wire         irdy [NI];
  wire         ov   [NI];
  wire  [15:0] dout [NI];
  wire  [3:0]  cnt  [NI];

  int          n_chk;
  int          n_fail;
  bit          chk_en;
  logic [15:0] mdl     [NI][8];
  int          mlen    [NI];
  logic [15:0] seq     [NI];
  int          pushes  [NI];
  int          dut_pops[NI];

  function automatic int dep_of(input int g);
    return (g == 1) ? 3 : (g == 2) ? 1 : 2;
  endfunction

  function automatic bit rp_of(input int g);
    return (g >= 2);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D  = (g == 1) ? 3 : (g == 2) ? 1 : 2;
    localparam bit RP = (g >= 2);
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] c;
    pipe_stage_buf #(.WIDTH(16), .DEPTH(D), .READY_PASS(RP)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (fl[g]),
      .in_valid (iv[g]),
      .in_ready (irdy[g]),
      .in_data  (din[g]),
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out_data (dout[g]),
      .count    (c)
    );
    assign cnt[g] = 4'(c);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: compare DUT against the model before the edge, then advance the model.
  task automatic step();
    bit push_v [NI];
    bit pop_v  [NI];
    #1;
    for (int g = 0; g < NI; g++) begin
      int d;
      bit e_ir;
      bit e_ov;
      d    = dep_of(g);
      e_ir = !fl[g] && ((mlen[g] < d) || (rp_of(g) && ordy[g]));
      e_ov = !fl[g] && (mlen[g] != 0);
      if (chk_en) begin
        chk($sformatf("g%0d_in_ready", g), 32'(irdy[g]), 32'(e_ir));
        chk($sformatf("g%0d_out_valid", g), 32'(ov[g]), 32'(e_ov));
        chk($sformatf("g%0d_count", g), 32'(cnt[g]), 32'(mlen[g]));
        chk($sformatf("g%0d_count_le_depth", g), 32'(cnt[g] <= 4'(d)), 32'd1);
        if (e_ov) begin
          chk($sformatf("g%0d_out_data", g), 32'(dout[g]), 32'(mdl[g][0]));
        end
        if (ov[g] && ordy[g]) dut_pops[g]++;
      end
      push_v[g] = iv[g] && e_ir;
      pop_v[g]  = e_ov && ordy[g];
    end
    @(posedge clk);
    for (int g = 0; g < NI; g++) begin
      if (reset || fl[g]) begin
        mlen[g] = 0;
      end else begin
        if (pop_v[g]) begin
          for (int k = 0; k < 7; k++) mdl[g][k] = mdl[g][k+1];
          mlen[g]--;
        end
        if (push_v[g]) begin
          mdl[g][mlen[g]] = din[g];
          mlen[g]++;
          pushes[g]++;
          seq[g] = seq[g] + 16'd1;
        end
      end
    end
    #1;
    for (int g = 0; g < NI; g++) din[g] = seq[g];
  endtask

  initial begin
    int base;
    int n;
    n_chk  = 0;
    n_fail = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    for (int g = 0; g < NI; g++) begin
      fl[g] = 0; iv[g] = 0; ordy[g] = 0;
      seq[g] = 16'd1; din[g] = 16'd1;
      mlen[g] = 0; pushes[g] = 0; dut_pops[g] = 0;
    end
    step();
    step();
    reset  = 1'b0;
    chk_en = 1'b1;
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("rst_g%0d_out_data", g), 32'(dout[g]), 32'd0);
      chk($sformatf("rst_g%0d_out_valid", g), 32'(ov[g]), 32'd0);
      chk($sformatf("rst_g%0d_in_ready", g), 32'(irdy[g]), 32'd1);
      chk($sformatf("rst_g%0d_count", g), 32'(cnt[g]), 32'd0);
    end

    // Depth 2, no pass-through: 1,2 accepted, 3 stalls until a slot frees.
    iv[0] = 1;
    step();
    step();
    chk("t1_count_full", 32'(cnt[0]), 32'd2);
    step();
    chk("t1_third_not_taken", 32'(seq[0]), 32'd3);
    ordy[0] = 1;
    n = 0;
    while ((seq[0] <= 16'd3 || mlen[0] != 0) && n < 20) begin
      if (seq[0] > 16'd3) iv[0] = 0;
      step();
      n++;
    end
    chk("t1_drain_in_time", 32'(n < 20), 32'd1);
    chk("t1_final_count", 32'(cnt[0]), 32'd0);
    iv[0] = 0; ordy[0] = 0;

    // Flush of a full buffer with both handshakes offered.
    seq[0] = 16'hA; din[0] = 16'hA; iv[0] = 1;
    step();
    seq[0] = 16'h5; din[0] = 16'h5;
    step();
    fl[0] = 1; ordy[0] = 1;
    #1;
    chk("flush_in_ready", 32'(irdy[0]), 32'd0);
    chk("flush_out_valid", 32'(ov[0]), 32'd0);
    step();
    fl[0] = 0; iv[0] = 0; ordy[0] = 0;
    #1;
    chk("post_flush_count", 32'(cnt[0]), 32'd0);
    chk("post_flush_out_valid", 32'(ov[0]), 32'd0);
    step();
    seq[0] = 16'hB; din[0] = 16'hB; iv[0] = 1;
    step();
    iv[0] = 0;
    #1;
    chk("refill_out_valid", 32'(ov[0]), 32'd1);
    chk("refill_out_data", 32'(dout[0]), 32'hB);
    ordy[0] = 1;
    step();
    ordy[0] = 0;

    // Reset beats flush on a full buffer.
    iv[0] = 1;
    step();
    step();
    iv[0] = 0; reset = 1; fl[0] = 1;
    step();
    reset = 0; fl[0] = 0;
    #1;
    chk("rst_full_count", 32'(cnt[0]), 32'd0);
    chk("rst_full_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_full_out_data", 32'(dout[0]), 32'd0);
    step();

    // Depth 1 with pass-through: 8 words in 9 cycles.
    base = dut_pops[2];
    iv[2] = 1; ordy[2] = 1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) iv[2] = 0;
      step();
    end
    chk("t4_delivered", 32'(dut_pops[2] - base), 32'd8);
    chk("t4_final_count", 32'(cnt[2]), 32'd0);
    iv[2] = 0; ordy[2] = 0;

    // Depth 2 with pass-through: full buffer streams at count 2.
    iv[3] = 1;
    step();
    step();
    ordy[3] = 1;
    for (int i = 0; i < 4; i++) step();
    chk("rp_full_count", 32'(cnt[3]), 32'd2);
    iv[3] = 0;
    for (int i = 0; i < 3; i++) step();
    chk("rp_drained", 32'(cnt[3]), 32'd0);
    ordy[3] = 0;

    // Depth 3: ten words through random stalls, pointers wrap repeatedly.
    base = pushes[1];
    n = dut_pops[1];
    for (int c = 0; c < 200; c++) begin
      if ((pushes[1] - base) >= 10 && mlen[1] == 0) break;
      iv[1]   = ((pushes[1] - base) < 10) && ($urandom_range(3) != 0);
      ordy[1] = ($urandom_range(2) != 0);
      step();
    end
    iv[1] = 0; ordy[1] = 0;
    chk("t3_accepted", 32'(pushes[1] - base), 32'd10);
    chk("t3_delivered", 32'(dut_pops[1] - n), 32'd10);
    chk("t3_final_count", 32'(cnt[1]), 32'd0);

    // Free-running random traffic on every configuration, with rare flushes.
    for (int c = 0; c < 400; c++) begin
      for (int g = 0; g < NI; g++) begin
        iv[g]   = ($urandom_range(3) != 0);
        ordy[g] = ($urandom_range(2) != 0);
        fl[g]   = ($urandom_range(19) == 0);
      end
      step();
    end
    for (int g = 0; g < NI; g++) begin
      iv[g] = 0; ordy[g] = 0; fl[g] = 0;
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
